// File: rtl/ls_mem_bridge_if.sv
// rtl/ls_mem_bridge_if.sv - controller handshake and data-memory signal bundle for ls_mem_bridge
interface ls_mem_bridge_if;
    // Controller side: four-phase request with bundled instruction data
    logic        req_i;
    logic        ack_o;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata_o;
    logic [1:0]  err_o;

    // Data-memory side: single-port synchronous memory with variable latency
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    // Environment view: the pipeline controller plus the data memory
    modport master (
        output req_i, opcode, funct3, addr, wdata, mem_rdata, mem_ready,
        input  ack_o, rdata_o, err_o, mem_req, mem_we, mem_be, mem_addr, mem_wdata
    );

    // Bridge view
    modport slave (
        input  req_i, opcode, funct3, addr, wdata, mem_rdata, mem_ready,
        output ack_o, rdata_o, err_o, mem_req, mem_we, mem_be, mem_addr, mem_wdata
    );
endinterface

// File: rtl/ls_mem_bridge.sv
// rtl/ls_mem_bridge.sv - four-phase load/store stage between the async controller and a sync data memory
module ls_mem_bridge #(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 15
) (
    input  logic           clk,
    input  logic           reset,
    ls_mem_bridge_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [6:0] OP_LOAD      = 7'b0000011;
    localparam logic [6:0] OP_STORE     = 7'b0100011;
    localparam logic [1:0] ERR_OK       = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
    localparam logic [1:0] ERR_FUNCT3   = 2'b11;
    localparam logic [7:0] TO_LAST      = 8'(TIMEOUT - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   req_s;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q;

    // Request attributes kept for formatting the load result at completion
    logic        is_load_q;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;

    logic        is_load, is_store, bad_f3, misaligned;
    logic [3:0]  be_d;
    logic [31:0] wdata_d;
    logic [7:0]  lbyte;
    logic [15:0] lhalf;
    logic [31:0] load_fmt;

    logic        accept, start_access, finish_ok, finish_to;
    logic [1:0]  err_d;

    assign req_s = sync_q[SYNC_STAGES-1];

    // Bring the asynchronous request into the clk domain
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.req_i};
        end
    end

    // Classify the bundled instruction; data is stable while req_i is high
    always_comb begin
        is_load  = (bus.opcode == OP_LOAD);
        is_store = (bus.opcode == OP_STORE);
        bad_f3   = 1'b0;
        if (is_load) begin
            bad_f3 = (bus.funct3 == 3'b011) || (bus.funct3 == 3'b110) || (bus.funct3 == 3'b111);
        end else if (is_store) begin
            bad_f3 = (bus.funct3 > 3'b010);
        end
        misaligned = ((bus.funct3[1:0] == 2'b01) && bus.addr[0]) ||
                     ((bus.funct3[1:0] == 2'b10) && (bus.addr[1:0] != 2'b00));
    end

    // Store lane steering: byte/half replicated so any lane the enables pick holds the data
    always_comb begin
        be_d    = 4'b1111;
        wdata_d = bus.wdata;
        if (is_store) begin
            case (bus.funct3[1:0])
                2'b00: begin
                    be_d    = 4'b0001 << bus.addr[1:0];
                    wdata_d = {4{bus.wdata[7:0]}};
                end
                2'b01: begin
                    be_d    = 4'b0011 << bus.addr[1:0];
                    wdata_d = {2{bus.wdata[15:0]}};
                end
                default: begin
                    be_d    = 4'b1111;
                    wdata_d = bus.wdata;
                end
            endcase
        end
    end

    // Load formatting: pick the addressed byte/half and extend per funct3
    always_comb begin
        case (off_q)
            2'd0:    lbyte = bus.mem_rdata[7:0];
            2'd1:    lbyte = bus.mem_rdata[15:8];
            2'd2:    lbyte = bus.mem_rdata[23:16];
            default: lbyte = bus.mem_rdata[31:24];
        endcase
        lhalf = off_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
        case (f3_q)
            3'b000:  load_fmt = {{24{lbyte[7]}}, lbyte};
            3'b100:  load_fmt = {24'd0, lbyte};
            3'b001:  load_fmt = {{16{lhalf[15]}}, lhalf};
            3'b101:  load_fmt = {16'd0, lhalf};
            default: load_fmt = bus.mem_rdata;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state and per-cycle control strobes
    always_comb begin
        state_d      = state_q;
        accept       = 1'b0;
        start_access = 1'b0;
        finish_ok    = 1'b0;
        finish_to    = 1'b0;
        err_d        = ERR_OK;
        case (state_q)
            IDLE: begin
                if (req_s) begin
                    accept = 1'b1;
                    if (!is_load && !is_store) begin
                        state_d = DONE;
                    end else if (bad_f3) begin
                        err_d   = ERR_FUNCT3;
                        state_d = DONE;
                    end else if (misaligned) begin
                        err_d   = ERR_MISALIGN;
                        state_d = DONE;
                    end else begin
                        start_access = 1'b1;
                        state_d      = ACCESS;
                    end
                end
            end
            ACCESS: begin
                // A ready on the last allowed cycle still wins over the timeout
                if (bus.mem_ready) begin
                    finish_ok = 1'b1;
                    state_d   = DONE;
                end else if (cnt_q == TO_LAST) begin
                    finish_to = 1'b1;
                    state_d   = DONE;
                end
            end
            DONE: begin
                if (!req_s) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Registered outputs, memory command capture, timeout counter and load result
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.ack_o     <= 1'b0;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_be    <= 4'b0000;
            bus.mem_addr  <= 32'd0;
            bus.mem_wdata <= 32'd0;
            bus.rdata_o   <= 32'd0;
            bus.err_o     <= ERR_OK;
            cnt_q         <= 8'd0;
            is_load_q     <= 1'b0;
            f3_q          <= 3'd0;
            off_q         <= 2'd0;
        end else begin
            bus.ack_o   <= (state_d == DONE);
            bus.mem_req <= (state_d == ACCESS);
            if (accept) begin
                bus.err_o <= err_d;
                is_load_q <= is_load;
                f3_q      <= bus.funct3;
                off_q     <= bus.addr[1:0];
            end
            if (start_access) begin
                bus.mem_we    <= is_store;
                bus.mem_be    <= be_d;
                bus.mem_addr  <= {bus.addr[31:2], 2'b00};
                bus.mem_wdata <= wdata_d;
                cnt_q         <= 8'd0;
            end else if ((state_q == ACCESS) && !bus.mem_ready) begin
                cnt_q <= cnt_q + 8'd1;
            end
            if (finish_to) begin
                bus.err_o <= ERR_TIMEOUT;
            end
            if (finish_ok && is_load_q) begin
                bus.rdata_o <= load_fmt;
            end
        end
    end
endmodule
